// File: rtl/fios_seq_ctrl.sv
// FIOS sequencer: paces b/p fetch bursts and a-register shifts per pass, then
// captures the PE-array result words into a small FIFO and hands them out.
module fios_seq_ctrl #(
  parameter int unsigned S          = 8,
  parameter int unsigned PE_NB      = 8,
  parameter int unsigned WORD_W     = 17,
  parameter int unsigned PE_DELAY   = 7,
  parameter int unsigned LOOP_DELAY = 0,
  parameter int unsigned RES_LAT    = 9
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              b_fetch_o,
  output logic              p_fetch_o,
  output logic              a_shift_o,
  input  logic [WORD_W-1:0] array_res_i,
  output logic [WORD_W-1:0] res_data_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              done_o
);

  localparam int unsigned P       = (S + PE_NB - 1) / PE_NB;
  localparam int unsigned PER     = PE_NB * PE_DELAY + LOOP_DELAY;
  localparam int unsigned L       = (S - 1) % PE_NB;
  localparam int unsigned C0OFF   = 1 + (P - 1) * PER + L * PE_DELAY + RES_LAT;
  localparam int unsigned CAP_END = C0OFF + S - 1;
  localparam int unsigned GAP_LEN = (PER > S) ? PER - S : 1;
  localparam int unsigned PTR_W   = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned CNT_W   = $clog2(PER + S + 1);
  localparam int unsigned PASS_W  = $clog2(P + 1);
  localparam int unsigned CYC_W   = $clog2(CAP_END + 2);
  localparam int unsigned POP_W   = $clog2(S + 1);

  if (S < 2) begin : g_bad_s
    $error("fios_seq_ctrl: S must be at least 2");
  end
  if (P > 1 && PER < S) begin : g_bad_per
    $error("fios_seq_ctrl: folded loop period shorter than S");
  end

  typedef enum logic [2:0] {IDLE, FETCH, GAP, DRAIN, OUT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PASS_W-1:0]  pass_q, pass_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [POP_W-1:0]   pop_cnt_q, pop_cnt_d;
  logic [POP_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0]  mem_q [S];
  logic [WORD_W-1:0]  res_data_q, head_c;
  logic               ready_q, busy_q, fetch_q, shift_q, valid_q, done_q, done_d;
  logic               capture_c, pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(S - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Sequencing, FIFO bookkeeping and abort flush
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    cyc_d     = cyc_q;
    pop_cnt_d = pop_cnt_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    done_d    = 1'b0;
    capture_c = (state_q != IDLE) && (cyc_q >= CYC_W'(C0OFF)) && (cyc_q <= CYC_W'(CAP_END));
    pop_c     = (count_q != '0) && res_ready_i;

    // cyc_q holds the edge index relative to the accepted start; it saturates
    if (state_q != IDLE && cyc_q <= CYC_W'(CAP_END)) cyc_d = cyc_q + CYC_W'(1);
    if (capture_c) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_c) begin
      rd_ptr_d  = ptr_inc(rd_ptr_q);
      pop_cnt_d = pop_cnt_q + POP_W'(1);
    end
    if (capture_c && !pop_c)      count_d = count_q + POP_W'(1);
    else if (!capture_c && pop_c) count_d = count_q - POP_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = FETCH;
          cnt_d     = '0;
          pass_d    = '0;
          cyc_d     = CYC_W'(1);
          pop_cnt_d = '0;
        end
      end
      FETCH: begin
        if (cnt_q == CNT_W'(S - 1)) begin
          cnt_d = '0;
          if (pass_q == PASS_W'(P - 1)) begin
            state_d = DRAIN;
          end else if (PER == S) begin
            pass_d = pass_q + PASS_W'(1);
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
          state_d = FETCH;
          cnt_d   = '0;
          pass_d  = pass_q + PASS_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cyc_q >= CYC_W'(CAP_END)) state_d = OUT;
      end
      OUT: begin
        if (pop_c && pop_cnt_q == POP_W'(S - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cyc_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && abort_i) begin
      state_d   = IDLE;
      cnt_d     = '0;
      pass_d    = '0;
      cyc_d     = '0;
      pop_cnt_d = '0;
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      done_d    = 1'b0;
    end

    // Word at the FIFO head after this edge, bypassing a same-edge capture
    head_c = (capture_c && wr_ptr_q == rd_ptr_d) ? array_res_i : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pass_q     <= '0;
      cyc_q      <= '0;
      pop_cnt_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      fetch_q    <= 1'b0;
      shift_q    <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      cyc_q      <= cyc_d;
      pop_cnt_q  <= pop_cnt_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ready_q    <= (state_d == IDLE);
      busy_q     <= (state_d != IDLE);
      fetch_q    <= (state_d == FETCH);
      shift_q    <= (state_d == FETCH) && (cnt_d == CNT_W'(S - 1));
      valid_q    <= (count_d != '0);
      done_q     <= done_d;
      res_data_q <= head_c;
    end
  end

  // Result storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clock_i) begin
    if (capture_c) mem_q[wr_ptr_q] <= array_res_i;
  end

  assign ready_o     = ready_q;
  assign busy_o      = busy_q;
  assign b_fetch_o   = fetch_q;
  assign p_fetch_o   = fetch_q;
  assign a_shift_o   = shift_q;
  assign res_valid_o = valid_q;
  assign res_data_o  = res_data_q;
  assign done_o      = done_q;

endmodule

// File: doc/fios_seq_ctrl.md
FIOS_SEQ_CTRL -- requirements
Module: fios_seq_ctrl

Interface
REQ-001 Parameter S, default 8, number of operand words per FIOS operation; must be at least 2.
REQ-002 Parameter PE_NB, default 8, number of PEs; the configuration is folded when PE_NB < S.
REQ-003 Parameter WORD_W, default 17, result word width.
REQ-004 Parameter PE_DELAY, default 7, cycles between consecutive PEs.
REQ-005 Parameter LOOP_DELAY, default 0, extra feedback cycles from the last PE back to PE0.
REQ-006 Parameter RES_LAT, default 9, cycles from a PE's first operand word to its first result word.
REQ-007 Port clock_i, input, 1 bit: single clock; all logic is synchronous to its rising edge.
REQ-008 Port reset_i, input, 1 bit: reset is synchronous and active-low.
REQ-009 Port start_i, input, 1 bit: operation request, qualified by ready_o.
REQ-010 Port abort_i, input, 1 bit: cancels the operation in flight.
REQ-011 Port ready_o, output, 1 bit: block is idle and will accept start_i.
REQ-012 Port busy_o, output, 1 bit: operation in flight (the inverse of ready_o).
REQ-013 Port b_fetch_o, output, 1 bit: fetch the next b word.
REQ-014 Port p_fetch_o, output, 1 bit: fetch the next p word.
REQ-015 Port a_shift_o, output, 1 bit: shift the a register by PE_NB words.
REQ-016 Port array_res_i, input, WORD_W bits: result word from the PE array.
REQ-017 Port res_data_o, output, WORD_W bits: result word at the FIFO head.
REQ-018 Port res_valid_o, output, 1 bit: res_data_o holds a valid word.
REQ-019 Port res_ready_i, input, 1 bit: consumer accepts the word on res_data_o.
REQ-020 Port done_o, output, 1 bit: one-cycle pulse when the final result word has been accepted.

Function
REQ-021 Derived values: P = ceil(S/PE_NB); PER = PE_NB*PE_DELAY + LOOP_DELAY; L = (S-1) mod PE_NB.
REQ-022 When P > 1 and PER < S, elaboration shall fail with $error.
REQ-023 FSM states: IDLE, FETCH, GAP, DRAIN, OUT.
REQ-024 start is accepted only when start_i = 1 and ready_o = 1 at a rising edge; call that edge T0.
REQ-025 start_i asserted in any state other than IDLE shall be ignored, with no side effects.
REQ-026 Pass k (k = 0..P-1) begins at cycle T0+1+k*PER.
REQ-027 b_fetch_o and p_fetch_o shall be high for exactly S consecutive cycles starting at the beginning of each pass (FETCH state).
REQ-028 a_shift_o shall be a single-cycle pulse coinciding with the last fetch cycle of each pass.
REQ-029 Between passes the FSM sits in GAP for PER-S cycles with all fetch outputs low; when PER = S there is no GAP and the next pass follows immediately.
REQ-030 After the last pass the FSM enters DRAIN.
REQ-031 Capture window: starting at C0 = T0+1+(P-1)*PER + L*PE_DELAY + RES_LAT, array_res_i is written into the internal FIFO for S consecutive cycles, one word per cycle in word order 0..S-1.
REQ-032 Capture is unconditional: it is never stalled by res_ready_i.
REQ-033 The FIFO depth is S; because only one operation is in flight at a time, overflow cannot occur.
REQ-034 The FIFO pointers are clog2(S)-bit and wrap modulo S.
REQ-035 res_valid_o = 1 whenever the FIFO is non-empty, including during capture (OUT overlaps DRAIN).
REQ-036 A word is popped when res_valid_o = 1 and res_ready_i = 1 at the same rising edge.
REQ-037 Words are delivered in capture order, with no loss or duplication under any res_ready_i pattern.
REQ-038 res_data_o is don't-care while res_valid_o = 0.
REQ-039 done_o pulses in the cycle after the S-th pop; in that same cycle ready_o = 1 and the FSM is in IDLE.
REQ-040 A start_i presented in the done_o cycle shall be accepted.
REQ-041 abort_i = 1 in any state other than IDLE: on the next cycle FSM = IDLE, FIFO flushed, all fetch/shift/valid outputs 0, ready_o = 1, and done_o is not asserted.
REQ-042 abort_i in IDLE has no effect.
REQ-043 If abort_i and start_i are both high in IDLE, the start is accepted.
REQ-044 A capture that is in progress when abort_i is taken is discarded.
REQ-045 A simultaneous pop and capture in the same cycle shall keep the FIFO count unchanged.

Reset
REQ-046 While reset_i = 0 at a rising edge: FSM = IDLE, counters and FIFO pointers = 0, ready_o = 1, busy_o = 0, and b_fetch_o, p_fetch_o, a_shift_o, res_valid_o, done_o = 0.
REQ-047 res_data_o shall reset to 0.
REQ-048 Reset asserted mid-operation aborts the operation exactly as abort_i does, and takes priority over abort_i and start_i.

Verification
REQ-049 Defaults (S=8, PE_NB=8), start at T0, res_ready_i=1 -> fetch high T0+1..T0+8; a_shift at T0+8; capture T0+59..T0+66; eight pops; done_o at T0+68.
REQ-050 Folded (S=8, PE_NB=3, PER=21, L=1) -> fetch bursts at T0+1..8, T0+22..29, T0+43..50; a_shift pulses at T0+8, T0+29, T0+50; capture starts at T0+59.
REQ-051 Defaults, res_ready_i=0 from T0+58 to T0+70, then 1 -> all 8 words 0..7 delivered in order; done_o one cycle after the 8th pop.
REQ-052 Defaults, start_i pulsed at T0+5 and T0+40 -> both ignored; exactly one fetch burst and one done_o.
REQ-053 Defaults, abort_i at T0+62 -> from T0+63: res_valid_o=0 and ready_o=1, no done_o; a new start at T0+65 produces a full, correct operation.
REQ-054 Defaults, reset_i=0 for one cycle at T0+30 -> all outputs at reset values the next cycle; no result words and no done_o for the aborted operation.
